// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that reuses a single 4-bit carry-lookahead slice,
// one nibble per cycle (LSB first), with valid/ready on both sides.
module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add1,
  input  logic [WIDTH-1:0] i_add2,
  input  logic             i_cin,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_cout,
  output logic             o_busy
);

  localparam int unsigned NIB   = WIDTH / 4;
  localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDX_W-1:0]      r_idx;
  logic [NIB-1:0][3:0]   r_a;
  logic [NIB-1:0][3:0]   r_b;
  logic [NIB-1:0][3:0]   r_result;
  logic [NIB-1:0][3:0]   w_result_nxt;
  logic                  r_carry;
  logic                  r_cout;
  logic                  r_ready;
  logic                  r_valid;
  logic                  r_busy;

  logic [3:0]            w_a_nib;
  logic [3:0]            w_b_nib;
  logic [3:0]            w_g;
  logic [3:0]            w_p;
  logic [3:0]            w_c;
  logic                  w_c4;
  logic [3:0]            w_sum;
  logic                  w_last;

  // Select the active nibble and merge the slice sum back into the result
  always_comb begin
    w_a_nib      = '0;
    w_b_nib      = '0;
    w_result_nxt = r_result;
    for (int unsigned i = 0; i < NIB; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_a_nib         = r_a[i];
        w_b_nib         = r_b[i];
        w_result_nxt[i] = w_sum;
      end
    end
  end

  // 4-bit carry-lookahead slice
  always_comb begin
    w_g    = w_a_nib & w_b_nib;
    w_p    = w_a_nib ^ w_b_nib;
    w_c[0] = r_carry;
    w_c[1] = w_g[0] | (w_p[0] & r_carry);
    w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_carry);
    w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
           | (w_p[2] & w_p[1] & w_p[0] & r_carry);
    w_c4   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
           | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_carry);
    w_sum  = w_p ^ w_c;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_last      = (r_idx == IDX_W'(NIB - 1));
    case (r_state)
      S_IDLE:  if (i_valid) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)  w_state_nxt = S_DONE;
      S_DONE:  if (i_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_ready  <= 1'b1;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == S_IDLE);
      r_valid <= (w_state_nxt == S_DONE);
      r_busy  <= (w_state_nxt != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            r_a      <= i_add1;
            r_b      <= i_add2;
            r_carry  <= i_cin;
            r_idx    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
          end
        end
        S_RUN: begin
          r_result <= w_result_nxt;
          r_carry  <= w_c4;
          if (w_last) begin
            r_cout <= w_c4;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_ready  = r_ready;
  assign o_valid  = r_valid;
  assign o_busy   = r_busy;
  assign o_result = r_result;
  assign o_cout   = r_cout;

endmodule
